// File: rtl/period_meter_pkg.sv
// Shared types and constants for the period meter and its helpers.
package period_meter_pkg;

    // FSM encoding of the period meter.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } state_e;

    // Legal range for the synchroniser depth on the async input.
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

endpackage

// File: rtl/period_meter_if.sv
// Result-side bundle of the period meter: measured period with valid/ack
// handshake plus the status flags seen by the consumer.
interface period_meter_if #(
    parameter int CNT_W = 32
) ();
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             period_ack;
    logic             overrun;
    logic             overflow;
    logic             busy;

    // Producer side (the meter).
    modport master (
        output period,
        output period_valid,
        output overrun,
        output overflow,
        output busy,
        input  period_ack
    );

    // Consumer side (readout logic).
    modport slave (
        input  period,
        input  period_valid,
        input  overrun,
        input  overflow,
        input  busy,
        output period_ack
    );
endinterface

// File: rtl/period_meter_sync_rise_det.sv
// Synchroniser chain for an asynchronous level plus rising-edge detector.
// rise is a one-cycle pulse when the synchronised level goes 0 -> 1.
module sync_rise_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   level_prev_q;
    logic                   level_prev_d;

    // Shift the async input through the chain; remember last synchronised level.
    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], async_in};
        level_prev_d = sync_q[SYNC_STAGES-1];
    end

    // Chain and edge register, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q       <= '0;
            level_prev_q <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            level_prev_q <= level_prev_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~level_prev_q;

endmodule

// File: rtl/period_meter.sv
// Period meter: counts clk cycles between consecutive rising edges of an
// asynchronous square wave and hands each result out via valid/ack.
// The interface instance connected to res must use the same CNT_W.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sig_in,
    input  logic                  start,
    input  logic                  stop,
    period_meter_if.master        res
);
    logic sig_level;
    logic sig_rise;
    logic meas_rise;

    state_e           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [CNT_W-1:0] period_q,   period_d;
    logic             valid_q,    valid_d;
    logic             overrun_q,  overrun_d;
    logic             overflow_q, overflow_d;
    logic             busy_q,     busy_d;

    // Counter has reached its ceiling and cannot represent a longer period.
    function automatic logic is_saturated(input logic [CNT_W-1:0] v);
        return &v;
    endfunction

    sync_rise_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (sig_in),
        .level    (sig_level),
        .rise     (sig_rise)
    );

    // A rise is only meaningful while the synchronised level is high.
    assign meas_rise = sig_rise & sig_level;

    // Next-state, counter, capture/handshake and sticky flag logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        period_d   = period_q;
        valid_d    = valid_q;
        overrun_d  = overrun_q;
        overflow_d = overflow_q;

        // Consumer takes the result; a capture below may re-raise valid.
        if (valid_q && res.period_ack) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d    = ST_ARM;
                    overrun_d  = 1'b0;
                    overflow_d = 1'b0;
                end
            end
            ST_ARM: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (meas_rise) begin
                    state_d = ST_MEAS;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_MEAS: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (meas_rise) begin
                    cnt_d = CNT_W'(1);
                    if (!valid_q || res.period_ack) begin
                        period_d = cnt_q;
                        valid_d  = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else if (is_saturated(cnt_q)) begin
                    state_d    = ST_ARM;
                    overflow_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
        end
    end

    assign res.period       = period_q;
    assign res.period_valid = valid_q;
    assign res.overrun      = overrun_q;
    assign res.overflow     = overflow_q;
    assign res.busy         = busy_q;

endmodule
